factorial_arbiter: RTL
======================

FACTORIAL_ARBITER -- requirements
Module: factorial_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles to wait for a factorial result.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester request strobe.
REQ-007 req_data  input  N_REQ x 4  per-requester operand n.
REQ-008 req_ready  output  N_REQ  one-hot accept; a request SHALL transfer when req_valid[i] and req_ready[i] are both high.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  result consumer accept.
REQ-011 resp_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-012 resp_data  output  46  n! result.
REQ-013 resp_error  output  1  set when the result timed out.
REQ-014 fact_in_data  output  4  operand to the factorial engine.
REQ-015 fact_in_valid  output  1  start pulse to the engine.
REQ-016 fact_out_data  input  46  engine result.
REQ-017 fact_out_valid  input  1  engine result strobe.
REQ-018 fact_out_busy  input  1  engine computing.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: when any req_valid bit is high and fact_out_busy is low, the block SHALL grant one requester round-robin, assert its req_ready for exactly one cycle, latch req_data and the grant index, and go to ISSUE.
REQ-021 Round-robin priority SHALL start at the index after the last granted requester; after reset the highest priority SHALL be requester 0.
REQ-022 ISSUE: the block SHALL drive fact_in_data with the latched operand, hold fact_in_valid high for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 WAIT: on fact_out_valid high, the block SHALL latch fact_out_data, clear the error flag, and go to RESP.
REQ-024 WAIT: if the counter reaches TIMEOUT-1 without fact_out_valid, the block SHALL set resp_data to 0 and resp_error to 1, and go to RESP.
REQ-025 When fact_out_valid and the timeout occur in the same cycle, fact_out_valid SHALL win.
REQ-026 RESP: resp_valid, resp_id, resp_data and resp_error SHALL stay stable until resp_ready is high; the block SHALL then return to IDLE on the next edge.
REQ-027 At most one request SHALL be in flight; req_ready SHALL be low in ISSUE, WAIT and RESP.
REQ-028 A grant SHALL NOT occur while fact_out_busy is high, even in IDLE.
REQ-029 fact_out_valid outside WAIT SHALL be ignored.
REQ-030 Minimum request-to-response latency SHALL be 2 cycles plus the engine latency.

Reset
REQ-031 On reset, state SHALL be IDLE, the round-robin pointer SHALL select requester 0, and the counter SHALL be 0.
REQ-032 On reset, req_ready, resp_valid, resp_error, fact_in_valid, resp_data, resp_id and fact_in_data SHALL all be 0.
REQ-033 Reset asserted mid-operation SHALL abandon the in-flight request with no response.

Structure
REQ-034 Package factorial_pkg SHALL hold IN_W=4, OUT_W=46, the state enum and the result typedef; FactorialBlk SHALL share it.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).
REQ-036 The engine SHALL NOT be instantiated inside this block; it connects at the top level.

Verification
REQ-037 Single request: req 1 with n=3 -> resp_id=1, resp_data=6, resp_error=0.
REQ-038 Simultaneous requests: req 0..3 all valid with n=5,0,4,15 -> responses in order id 0,1,2,3 with data 120, 1, 24, 1307674368000.
REQ-039 Fairness: req 0 held continuously and req 2 valid -> grants alternate 0,2,0,2.
REQ-040 Backpressure: resp_ready held low for 10 cycles -> response stable and no new grant; release -> one response, then IDLE.
REQ-041 Timeout: stubbed engine never raises fact_out_valid -> after 64 WAIT cycles, resp_error=1 and resp_data=0.
REQ-042 Reset mid-WAIT -> all outputs 0 next cycle; a stale fact_out_valid is ignored; the next request (n=3) returns 6.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared widths, FSM states and result payload for the factorial request arbiter.
package factorial_pkg;

   localparam int unsigned IN_W  = 4;
   localparam int unsigned OUT_W = 46;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fact_state_t;

   typedef struct packed {
      logic             error;
      logic [OUT_W-1:0] data;
   } fact_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: ptr names the requester that currently has top priority.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         grant
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   logic            found;
   logic [ID_W-1:0] idx;

   // Scan from ptr upward with wrap; the first active request wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = ID_W'((32'(ptr) + i) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/factorial_arbiter.sv
// Shares one external factorial engine among N_REQ requesters, one request in flight,
// with a response timeout that reports an error instead of hanging.
module factorial_arbiter
   import factorial_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*IN_W-1:0]    req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [$clog2(N_REQ)-1:0] resp_id,
   output logic [OUT_W-1:0]         resp_data,
   output logic                     resp_error,
   output logic [IN_W-1:0]          fact_in_data,
   output logic                     fact_in_valid,
   input  logic [OUT_W-1:0]         fact_out_data,
   input  logic                     fact_out_valid,
   input  logic                     fact_out_busy
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   fact_state_t                state, state_n;
   logic [ID_W-1:0]            ptr, ptr_n;
   logic [CNT_W-1:0]           cnt, cnt_n;
   logic [N_REQ-1:0]           req_ready_n;
   logic                       fact_in_valid_n;
   logic [IN_W-1:0]            fact_in_data_n;
   logic                       resp_valid_n;
   logic [ID_W-1:0]            resp_id_n;
   fact_result_t               result, result_n;

   logic [N_REQ-1:0]           grant;
   logic [N_REQ-1:0][IN_W-1:0] req_data_a;
   logic [ID_W-1:0]            sel_id;
   logic [IN_W-1:0]            sel_data;

   assign req_data_a = req_data;
   assign resp_data  = result.data;
   assign resp_error = result.error;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   // Index and operand of the requester currently offered req_ready.
   always_comb begin
      sel_id   = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[ID_W'(i)]) begin
            sel_id   = ID_W'(i);
            sel_data = req_data_a[ID_W'(i)];
         end
      end
   end

   // Next-state and next-output logic. req_ready is offered for one IDLE cycle;
   // the transfer happens on the edge that closes that cycle if valid is still high.
   always_comb begin
      state_n         = state;
      ptr_n           = ptr;
      cnt_n           = cnt;
      req_ready_n     = '0;
      fact_in_valid_n = 1'b0;
      fact_in_data_n  = fact_in_data;
      resp_valid_n    = resp_valid;
      resp_id_n       = resp_id;
      result_n        = result;

      case (state)
         IDLE: begin
            if (req_ready != '0) begin
               if ((req_valid & req_ready) != '0) begin
                  fact_in_data_n  = sel_data;
                  fact_in_valid_n = 1'b1;
                  resp_id_n       = sel_id;
                  ptr_n           = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + ID_W'(1);
                  state_n         = ISSUE;
               end
            end else if (req_valid != '0 && !fact_out_busy) begin
               req_ready_n = grant;
            end
         end
         ISSUE: begin
            cnt_n   = '0;
            state_n = WAIT;
         end
         WAIT: begin
            // An engine result in the timeout cycle still counts as a good result.
            if (fact_out_valid) begin
               result_n     = '{error: 1'b0, data: fact_out_data};
               resp_valid_n = 1'b1;
               state_n      = RESP;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               result_n     = '{error: 1'b1, data: '0};
               resp_valid_n = 1'b1;
               state_n      = RESP;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_n = 1'b0;
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= '0;
         cnt           <= '0;
         req_ready     <= '0;
         fact_in_valid <= 1'b0;
         fact_in_data  <= '0;
         resp_valid    <= 1'b0;
         resp_id       <= '0;
         result        <= '0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         cnt           <= cnt_n;
         req_ready     <= req_ready_n;
         fact_in_valid <= fact_in_valid_n;
         fact_in_data  <= fact_in_data_n;
         resp_valid    <= resp_valid_n;
         resp_id       <= resp_id_n;
         result        <= result_n;
      end
   end

endmodule
